apb_rom_arbiter: RTL and testbench

APB master-side arbiter that shares the single APB slave plus rotor-mapping ROM between NREQ internal requesters, e.g. Enigma rotor stages and the configuration loader.
- Round-robin grant per transaction.
- Sequences each grant through a full APB SETUP/ACCESS transfer.
- Returns read data and error to the granted requester.
- Aborts transfers that exceed a pready timeout.
- Sits between the Enigma datapath and apb_slave_wrapper.

---
 rtl/apb_arb_pkg.sv | 20 ++
 rtl/apb_rom_arbiter_if.sv | 26 ++
 rtl/apb_rom_arbiter_rr_pick.sv | 30 +++
 rtl/apb_rom_arbiter.sv | 144 ++++++++++++++
 tb/tb_apb_rom_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/apb_arb_pkg.sv
// Shared types and constants for the APB ROM arbiter: FSM state encoding,
// fixed APB sideband values and the timeout counter width helper.
package apb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } arb_state_e;

    localparam logic PROT_DEFAULT = 1'b0;
    localparam logic STRB_DEFAULT = 1'b1;

    // A disabled timeout (0) still needs a 1-bit counter to stay legal.
    function automatic int cnt_width(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/apb_rom_arbiter_if.sv
// APB bus between the arbiter (master) and the slave wrapper / rotor ROM.
interface apb_rom_arbiter_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
);
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_WIDTH-1:0] paddr;
    logic [DATA_WIDTH-1:0] pwdata;
    logic                  prot;
    logic                  pstrb;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  pslverror;
    logic                  pready;

    modport master (
        output psel, penable, pwrite, paddr, pwdata, prot, pstrb,
        input  prdata, pslverror, pready
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata, prot, pstrb,
        output prdata, pslverror, pready
    );
endinterface

// File: rtl/apb_rom_arbiter_rr_pick.sv
// Combinational round-robin selector: searches upward from the slot after
// the last winner, wrapping modulo NREQ.
module rr_pick #(
    parameter  int NREQ = 2,
    localparam int IW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   idx,
    output logic            valid
);

    always_comb begin
        int j;
        j     = 0;
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            j = (int'(last) + k) % NREQ;
            if (!valid && req[IW'(j)]) begin
                valid          = 1'b1;
                gnt[IW'(j)]    = 1'b1;
                idx            = IW'(j);
            end
        end
    end

endmodule

// File: rtl/apb_rom_arbiter.sv
// Shares one APB slave between NREQ requesters, one full SETUP/ACCESS
// transfer per round-robin grant, with an optional pready timeout.
//
//   state  | meaning
//   IDLE   | no transfer; arbitrate and register the winner's request
//   SETUP  | psel=1, penable=0
//   ACCESS | psel=1, penable=1; wait for pready or timeout
//   RESP   | bus released; done pulse to the granted requester
module apb_rom_arbiter
    import apb_arb_pkg::*;
#(
    parameter int NREQ       = 2,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int TIMEOUT    = 16
) (
    input  logic                       clock,
    input  logic                       ares,
    input  logic [NREQ-1:0]            req,
    input  logic [NREQ-1:0]            req_write,
    input  logic [NREQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NREQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NREQ-1:0]            gnt,
    output logic [NREQ-1:0]            done,
    output logic [DATA_WIDTH-1:0]      rsp_rdata,
    output logic                       rsp_err,
    output logic                       busy,
    apb_rom_arbiter_if.master          apb
);

    localparam int             IW     = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int             CW     = cnt_width(TIMEOUT);
    localparam logic [CW-1:0]  TO_VAL = CW'(TIMEOUT);

    arb_state_e            state;
    logic [IW-1:0]         last;
    logic                  psel_q;
    logic                  penable_q;
    logic                  pwrite_q;
    logic [ADDR_WIDTH-1:0] paddr_q;
    logic [DATA_WIDTH-1:0] pwdata_q;
    logic [CW-1:0]         cnt;
    logic [CW-1:0]         cnt_inc;
    logic                  timeout_hit;

    logic [NREQ-1:0]       pick_gnt;
    logic [IW-1:0]         pick_idx;
    logic                  pick_valid;

    logic [ADDR_WIDTH-1:0] addr_slot  [NREQ];
    logic [DATA_WIDTH-1:0] wdata_slot [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_slot
        assign addr_slot[i]  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        assign wdata_slot[i] = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
    end

    rr_pick #(.NREQ(NREQ)) u_rr_pick (
        .req   (req),
        .last  (last),
        .gnt   (pick_gnt),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    // Saturating so a disabled timeout can sit in ACCESS indefinitely.
    assign cnt_inc     = (&cnt) ? cnt : cnt + 1'b1;
    assign timeout_hit = (TIMEOUT != 0) && (cnt_inc == TO_VAL);

    always_ff @(posedge clock) begin
        if (ares) begin
            state     <= IDLE;
            last      <= IW'(NREQ - 1);
            gnt       <= '0;
            done      <= '0;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            busy      <= 1'b0;
            cnt       <= '0;
        end else begin
            done <= '0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        gnt       <= pick_gnt;
                        last      <= pick_idx;
                        paddr_q   <= addr_slot[pick_idx];
                        pwdata_q  <= wdata_slot[pick_idx];
                        pwrite_q  <= req_write[pick_idx];
                        psel_q    <= 1'b1;
                        penable_q <= 1'b0;
                        busy      <= 1'b1;
                        state     <= SETUP;
                    end
                end
                SETUP: begin
                    penable_q <= 1'b1;
                    state     <= ACCESS;
                end
                ACCESS: begin
                    if (apb.pready) begin
                        rsp_rdata <= pwrite_q ? '0 : apb.prdata;
                        rsp_err   <= apb.pslverror;
                        psel_q    <= 1'b0;
                        penable_q <= 1'b0;
                        done      <= gnt;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt_inc;
                        if (timeout_hit) begin
                            rsp_rdata <= '0;
                            rsp_err   <= 1'b1;
                            psel_q    <= 1'b0;
                            penable_q <= 1'b0;
                            done      <= gnt;
                            state     <= RESP;
                        end
                    end
                end
                RESP: begin
                    gnt   <= '0;
                    cnt   <= '0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign apb.psel    = psel_q;
    assign apb.penable = penable_q;
    assign apb.pwrite  = pwrite_q;
    assign apb.paddr   = paddr_q;
    assign apb.pwdata  = pwdata_q;
    assign apb.prot    = PROT_DEFAULT;
    assign apb.pstrb   = STRB_DEFAULT;

endmodule

// File: tb/tb_apb_rom_arbiter.sv
// Bench for apb_rom_arbiter: transaction-timeline model checked every cycle,
// a behavioural APB slave, and directed scenarios with literal expectations.
module tb_apb_rom_arbiter;

    localparam int NREQ = 2;
    localparam int AW   = 5;
    localparam int DW   = 32;
    localparam int TO   = 16;

    logic              clock = 1'b0;
    logic              ares;
    logic [NREQ-1:0]   req;
    logic [NREQ-1:0]   req_write;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   done;
    logic [DW-1:0]     rsp_rdata;
    logic              rsp_err;
    logic              busy;

    apb_rom_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) apb_bus ();

    apb_rom_arbiter #(
        .NREQ(NREQ), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TO)
    ) dut (
        .clock     (clock),
        .ares      (ares),
        .req       (req),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .gnt       (gnt),
        .done      (done),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .apb       (apb_bus)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    // Slave behaviour knobs and backing memory
    int          sl_wait  = 0;
    bit          sl_stuck = 1'b0;
    bit          sl_err   = 1'b0;
    logic [DW-1:0] rom [32];
    int          acc_cnt  = 0;

    // Transaction-level model: one active transfer described by its SETUP
    // cycle, its number of ACCESS cycles and its expected response.
    bit            chk_en   = 1'b0;
    bit            m_active = 1'b0;
    int            m_last   = NREQ - 1;
    int            m_idx    = 0;
    int            m_t0     = 0;
    int            m_acc    = 0;
    bit            m_wr     = 1'b0;
    logic [AW-1:0] m_addr   = '0;
    logic [DW-1:0] m_wd     = '0;
    logic [DW-1:0] m_rd     = '0;
    bit            m_err    = 1'b0;

    function automatic int rr_next(input int lst, input logic [NREQ-1:0] r);
        for (int k = 1; k <= NREQ; k++) begin
            int j;
            j = (lst + k) % NREQ;
            if (r[j]) return j;
        end
        return -1;
    endfunction

    always @(negedge clock) begin
        int k;
        int nx;
        bit tmo;
        logic [NREQ-1:0] oh;
        k  = cyc - m_t0;
        oh = NREQ'(1) << m_idx;
        if (chk_en) begin
            if (m_active) begin
                chk("m_psel",    apb_bus.psel,    (k <= m_acc));
                chk("m_penable", apb_bus.penable, (k >= 1 && k <= m_acc));
                chk("m_gnt",     gnt,  oh);
                chk("m_done",    done, (k == m_acc + 1) ? oh : '0);
                chk("m_busy",    busy, 1);
                if (k <= m_acc) begin
                    chk("m_paddr",  apb_bus.paddr,  m_addr);
                    chk("m_pwrite", apb_bus.pwrite, m_wr);
                    chk("m_pwdata", apb_bus.pwdata, m_wd);
                end
                if (k == m_acc + 1) begin
                    chk("m_rdata", rsp_rdata, m_rd);
                    chk("m_err",   rsp_err,   m_err);
                end
            end else begin
                chk("m_idle_psel",    apb_bus.psel,    0);
                chk("m_idle_penable", apb_bus.penable, 0);
                chk("m_idle_gnt",     gnt,  0);
                chk("m_idle_done",    done, 0);
                chk("m_idle_busy",    busy, 0);
            end
            chk("m_prot",  apb_bus.prot,  0);
            chk("m_pstrb", apb_bus.pstrb, 1);
        end

        if (ares) begin
            m_active = 1'b0;
            m_last   = NREQ - 1;
            chk_en   = 1'b1;
        end else if (m_active) begin
            if (k == m_acc + 1) m_active = 1'b0;
        end else begin
            nx = rr_next(m_last, req);
            if (nx >= 0) begin
                m_idx    = nx;
                m_last   = nx;
                m_active = 1'b1;
                m_t0     = cyc + 1;
                m_wr     = req_write[nx];
                m_addr   = req_addr[nx*AW +: AW];
                m_wd     = req_wdata[nx*DW +: DW];
                tmo      = sl_stuck || (sl_wait + 1 > TO);
                m_acc    = tmo ? TO : sl_wait + 1;
                m_err    = tmo ? 1'b1 : sl_err;
                m_rd     = (tmo || m_wr) ? '0 : rom[m_addr];
            end
        end

        // Slave: pready held high outside ACCESS, which the arbiter must ignore.
        if (apb_bus.psel && apb_bus.penable) begin
            acc_cnt++;
            apb_bus.pready = !sl_stuck && (acc_cnt == sl_wait + 1);
        end else begin
            acc_cnt = 0;
            apb_bus.pready = 1'b1;
        end
        apb_bus.pslverror = sl_err;
        apb_bus.prdata    = rom[apb_bus.paddr];
    end

    int t_issue;

    task automatic issue(input int i, input bit wr, input int addr, input logic [DW-1:0] wd);
        @(posedge clock); #1;
        req_write[i]           = wr;
        req_addr[i*AW +: AW]   = AW'(addr);
        req_wdata[i*DW +: DW]  = wd;
        req[i]                 = 1'b1;
        t_issue                = cyc;
    endtask

    task automatic wait_any(output int idx, output int dc, output logic [DW-1:0] rd, output logic er);
        bit got;
        got = 1'b0; idx = -1; dc = -1; rd = '0; er = 1'b0;
        for (int n = 0; n < 64 && !got; n++) begin
            @(negedge clock);
            if (done != '0) begin
                got = 1'b1;
                idx = done[1] ? 1 : 0;
                dc  = cyc;
                rd  = rsp_rdata;
                er  = rsp_err;
            end
        end
        chk("done_seen", got, 1);
    endtask

    task automatic drop(input int i);
        @(posedge clock); #1;
        req[i] = 1'b0;
    endtask

    task automatic pulse_reset();
        @(posedge clock); #1; ares = 1'b1;
        @(posedge clock); #1; ares = 1'b0;
    endtask

    initial begin
        int i, dc, prev, n0;
        logic [DW-1:0] rd;
        logic er;
        ares = 1'b1; req = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        for (int a = 0; a < 32; a++) rom[a] = 32'h100 + a;
        rom[5] = 32'h0000_0013;
        rom[9] = 32'hDEAD_BEEF;
        repeat (3) @(posedge clock);
        #1 ares = 1'b0;

        @(negedge clock);
        chk("rst_gnt",   gnt, 0);
        chk("rst_done",  done, 0);
        chk("rst_busy",  busy, 0);
        chk("rst_rdata", rsp_rdata, 0);
        chk("rst_paddr", apb_bus.paddr, 0);

        // Single zero-wait read
        issue(0, 0, 5, '0);
        n0 = t_issue;
        @(negedge clock);
        @(negedge clock);
        chk("t1_psel_n1",    apb_bus.psel, 1);
        chk("t1_penable_n1", apb_bus.penable, 0);
        @(negedge clock);
        chk("t1_penable_n2", apb_bus.penable, 1);
        wait_any(i, dc, rd, er);
        chk("t1_idx", i, 0);
        chk("t1_done_cyc", dc, n0 + 3);
        chk("t1_rdata", rd, 32'h13);
        chk("t1_err", er, 0);
        drop(0);

        // Contention right after reset: 0,1,0,1 spaced 4 cycles
        pulse_reset();
        @(posedge clock); #1;
        req_addr  = {5'd2, 5'd1};
        req_write = '0;
        req       = 2'b11;
        n0        = cyc;
        prev      = 0;
        for (int t = 0; t < 4; t++) begin
            wait_any(i, dc, rd, er);
            chk("t2_idx", i, t % 2);
            chk("t2_rdata", rd, (t % 2 == 0) ? 32'h101 : 32'h102);
            if (t == 0) chk("t2_first_done", dc, n0 + 3);
            else        chk("t2_spacing", dc - prev, 4);
            prev = dc;
        end
        @(posedge clock); #1; req = '0;

        // Write with 3 wait states
        sl_wait = 3;
        issue(1, 1, 7, 32'hA5A5_0001);
        n0 = t_issue;
        wait_any(i, dc, rd, er);
        chk("t3_idx", i, 1);
        chk("t3_done_cyc", dc, n0 + 6);
        chk("t3_rdata", rd, 0);
        chk("t3_err", er, 0);
        drop(1);
        sl_wait = 0;

        // Timeout, then normal service
        sl_stuck = 1'b1;
        issue(0, 0, 3, '0);
        n0 = t_issue;
        wait_any(i, dc, rd, er);
        chk("t4_idx", i, 0);
        chk("t4_done_cyc", dc, n0 + 18);
        chk("t4_rdata", rd, 0);
        chk("t4_err", er, 1);
        drop(0);
        sl_stuck = 1'b0;
        issue(1, 0, 3, '0);
        n0 = t_issue;
        wait_any(i, dc, rd, er);
        chk("t4b_done_cyc", dc, n0 + 3);
        chk("t4b_rdata", rd, 32'h103);
        chk("t4b_err", er, 0);
        drop(1);

        // Slave error with data
        sl_err = 1'b1;
        issue(0, 0, 9, '0);
        wait_any(i, dc, rd, er);
        chk("t5_rdata", rd, 32'hDEAD_BEEF);
        chk("t5_err", er, 1);
        drop(0);
        sl_err = 1'b0;

        // Reset during ACCESS of requester 1
        sl_wait = 5;
        issue(1, 0, 2, '0);
        n0 = t_issue;
        repeat (3) begin @(posedge clock); #1; end
        ares    = 1'b1;
        sl_wait = 0;
        @(posedge clock); #1;
        ares = 1'b0;
        req_addr[0 +: AW] = 5'd4;
        req_write[0]      = 1'b0;
        req[0]            = 1'b1;
        @(negedge clock);
        chk("t6_psel",    apb_bus.psel, 0);
        chk("t6_penable", apb_bus.penable, 0);
        chk("t6_gnt",     gnt, 0);
        chk("t6_done",    done, 0);
        wait_any(i, dc, rd, er);
        chk("t6_first_idx", i, 0);
        chk("t6_first_cyc", dc, n0 + 7);
        chk("t6_first_rdata", rd, 32'h104);
        drop(0);
        wait_any(i, dc, rd, er);
        chk("t6_second_idx", i, 1);
        chk("t6_second_rdata", rd, 32'h102);
        drop(1);

        repeat (3) @(posedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
